fp_add_arbiter: RTL

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP adder among N_REQ requesters.
// Per-requester credits bound in-flight work plus buffered results, so each
// response FIFO always has room for the results that are already in the pipe.
module fp_add_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned LAT        = 2,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [32*N_REQ-1:0]  rsp_result,
  output logic [31:0]          core_a,
  output logic [31:0]          core_b,
  input  logic [31:0]          core_result,
  output logic                 busy
);

  localparam int unsigned DW    = 32;
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned AW    = $clog2(RESP_DEPTH);
  localparam int unsigned PW    = AW + 1;

  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt [N_REQ];
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;
  logic             grant_valid;
  logic [PTR_W-1:0] grant_idx;

  logic             tag_valid [LAT+1];
  logic [PTR_W-1:0] tag_id    [LAT+1];

  logic [DW-1:0]    mem  [N_REQ][RESP_DEPTH];
  logic [PW-1:0]    wptr [N_REQ];
  logic [PW-1:0]    rptr [N_REQ];

  // A requester may be granted only while it holds a free credit
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      eligible[i] = !reset && req_valid[i] && (cnt[i] < CNT_W'(RESP_DEPTH));
    end
  end

  // Round-robin pick: first eligible index at or after ptr
  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    req_ready   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (!grant_valid && eligible[PTR_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
    if (grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Pointer, operand registers and the tag pipeline that tracks adder results
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      core_a <= '0;
      core_b <= '0;
      for (int unsigned k = 0; k <= LAT; k++) begin
        tag_valid[k] <= 1'b0;
        tag_id[k]    <= '0;
      end
    end else begin
      if (grant_valid) begin
        core_a <= req_a[DW*32'(grant_idx) +: DW];
        core_b <= req_b[DW*32'(grant_idx) +: DW];
        ptr    <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      tag_valid[0] <= grant_valid;
      tag_id[0]    <= grant_idx;
      for (int unsigned k = 1; k <= LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  // Result lands in the FIFO of the tagged requester; pops follow the handshake
  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      push[i] = tag_valid[LAT] && (tag_id[LAT] == PTR_W'(i));
      pop[i]  = rsp_valid[i] && rsp_ready[i];
    end
  end

  // FIFO heads are presented directly from storage, never from core_result
  always_comb begin
    rsp_valid  = '0;
    rsp_result = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_valid[i]            = !reset && (wptr[i] != rptr[i]);
      rsp_result[DW*i +: DW]  = mem[i][rptr[i][AW-1:0]];
    end
  end

  // Busy while any requester has work in flight or buffered
  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (cnt[i] != '0) begin
        busy = 1'b1;
      end
    end
    if (reset) begin
      busy = 1'b0;
    end
  end

  // Credit counters and FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cnt[i]  <= '0;
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (push[i]) begin
          wptr[i] <= wptr[i] + PW'(1);
        end
        if (pop[i]) begin
          rptr[i] <= rptr[i] + PW'(1);
        end
        if (req_ready[i] && !pop[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (!req_ready[i] && pop[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (push[i]) begin
          mem[i][wptr[i][AW-1:0]] <= core_result;
        end
      end
    end
  end

endmodule
